// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: one memory port and one ALU are shared across
// the FETCH/DECODE/EXE/MEM/WB steps, and every memory access waits on mem_ready.
module mc_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  Op,
   input  logic [5:0]  Funct,
   input  logic        Zero,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IorD,
   output logic        RegWrite,
   output logic        ALUSrcB,
   output logic        EXTOp,
   output logic [4:0]  ALUOp,
   output logic [3:0]  NPCOp,
   output logic [1:0]  GPRSel,
   output logic [1:0]  WDSel,
   output logic [3:0]  LOADSel,
   output logic        illegal,
   output logic [2:0]  state,
   output logic [31:0] instret
);

   localparam int unsigned ALUW = 5;
   localparam int unsigned NPCW = 4;
   localparam int unsigned SELW = 2;
   localparam int unsigned LSW  = 4;
   localparam int unsigned CNTW = 32;

   typedef enum logic [2:0] {
      S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      C_RALU, C_IALU, C_LOAD, C_STORE, C_BR, C_J, C_ILL
   } cls_t;

   state_t              state_q, state_d, st_eff;
   logic [CNTW-1:0]     instret_q;
   cls_t                cls;
   logic [ALUW-1:0]     d_alu, r_alu;
   logic                d_srcb, d_ext, d_link;
   logic [SELW-1:0]     d_gpr, d_wd;
   logic [LSW-1:0]      d_lsel;
   logic [NPCW-1:0]     d_npc;
   logic                sel_en, br_taken;

   // Instruction decode: class plus the datapath selects shared with the single-cycle core.
   always_comb begin
      cls    = C_ILL;
      d_alu  = '0;
      d_srcb = 1'b0;
      d_ext  = 1'b0;
      d_gpr  = '0;
      d_wd   = '0;
      d_lsel = '0;
      d_npc  = '0;
      d_link = 1'b0;
      r_alu  = '0;
      unique case (Funct)
         6'h20, 6'h21: r_alu = ALUW'(1);
         6'h22, 6'h23: r_alu = ALUW'(2);
         6'h24:        r_alu = ALUW'(3);
         6'h25:        r_alu = ALUW'(4);
         6'h2A:        r_alu = ALUW'(5);
         6'h2B:        r_alu = ALUW'(6);
         6'h00:        r_alu = ALUW'(7);
         6'h27:        r_alu = ALUW'(8);
         6'h02:        r_alu = ALUW'(10);
         6'h04:        r_alu = ALUW'(11);
         6'h26:        r_alu = ALUW'(12);
         6'h03:        r_alu = ALUW'(13);
         6'h07:        r_alu = ALUW'(14);
         6'h06:        r_alu = ALUW'(15);
         default:      r_alu = '0;
      endcase
      case (Op)
         6'h00: begin
            if (r_alu != '0) begin
               cls   = C_RALU;
               d_alu = r_alu;
            end else if (Funct == 6'h08) begin
               cls   = C_J;
               d_npc = NPCW'(3);
            end else if (Funct == 6'h09) begin
               cls    = C_J;
               d_npc  = NPCW'(4);
               d_link = 1'b1;
               d_wd   = SELW'(2);
            end
         end
         6'h02: begin
            cls   = C_J;
            d_npc = NPCW'(2);
         end
         6'h03: begin
            cls    = C_J;
            d_npc  = NPCW'(2);
            d_link = 1'b1;
            d_gpr  = SELW'(2);
            d_wd   = SELW'(2);
         end
         6'h04, 6'h05: begin
            cls   = C_BR;
            d_alu = ALUW'(2);
            d_ext = 1'b1;
         end
         6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin
            cls    = C_IALU;
            d_srcb = 1'b1;
            d_gpr  = SELW'(1);
            d_ext  = (Op == 6'h08) || (Op == 6'h0A);
            case (Op)
               6'h08:   d_alu = ALUW'(1);
               6'h0A:   d_alu = ALUW'(5);
               6'h0C:   d_alu = ALUW'(3);
               6'h0D:   d_alu = ALUW'(4);
               default: d_alu = ALUW'(9);
            endcase
         end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
            cls    = C_LOAD;
            d_alu  = ALUW'(1);
            d_srcb = 1'b1;
            d_ext  = 1'b1;
            d_gpr  = SELW'(1);
            d_wd   = SELW'(1);
            case (Op)
               6'h20:   d_lsel = LSW'(1);
               6'h24:   d_lsel = LSW'(2);
               6'h21:   d_lsel = LSW'(3);
               6'h25:   d_lsel = LSW'(4);
               default: d_lsel = LSW'(0);
            endcase
         end
         6'h28, 6'h29, 6'h2B: begin
            cls    = C_STORE;
            d_alu  = ALUW'(1);
            d_srcb = 1'b1;
            d_ext  = 1'b1;
            case (Op)
               6'h28:   d_lsel = LSW'(5);
               6'h29:   d_lsel = LSW'(6);
               default: d_lsel = LSW'(0);
            endcase
         end
         default: cls = C_ILL;
      endcase
   end

   assign st_eff   = rst ? S_FETCH : state_q;
   assign sel_en   = (st_eff != S_FETCH);
   assign br_taken = (Op == 6'h05) ? ~Zero : Zero;

   // Next-state and strobe generation; reset kills every strobe in the same cycle.
   always_comb begin
      state_d  = state_q;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      RegWrite = 1'b0;
      NPCOp    = '0;
      illegal  = 1'b0;
      ALUOp    = sel_en ? d_alu  : '0;
      ALUSrcB  = sel_en ? d_srcb : 1'b0;
      EXTOp    = sel_en ? d_ext  : 1'b0;
      GPRSel   = sel_en ? d_gpr  : '0;
      WDSel    = sel_en ? d_wd   : '0;
      LOADSel  = sel_en ? d_lsel : '0;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            if (mem_ready) begin
               IRWrite = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (cls == C_J) begin
               PCWrite  = 1'b1;
               NPCOp    = d_npc;
               RegWrite = d_link;
               state_d  = S_FETCH;
            end else if (cls == C_ILL) begin
               PCWrite = 1'b1;
               illegal = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_EXE;
            end
         end
         S_EXE: begin
            if (cls == C_BR) begin
               PCWrite = 1'b1;
               NPCOp   = br_taken ? NPCW'(1) : NPCW'(0);
               state_d = S_FETCH;
            end else if (cls == C_LOAD || cls == C_STORE) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            IorD     = 1'b1;
            MemRead  = (cls == C_LOAD);
            MemWrite = (cls == C_STORE);
            if (mem_ready) begin
               if (cls == C_STORE) begin
                  PCWrite = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            PCWrite  = 1'b1;
            state_d  = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      if (rst) begin
         state_d  = S_FETCH;
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         IorD     = 1'b0;
         RegWrite = 1'b0;
         NPCOp    = '0;
         illegal  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (PCWrite) instret_q <= instret_q + CNTW'(1);
      end
   end

   assign state   = 3'(st_eff);
   assign instret = rst ? '0 : instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction phase lists built from the class
// rules are compared cycle by cycle against every DUT output.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst, Zero, mem_ready;
   logic [5:0]  Op, Funct;
   logic        PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, ALUSrcB, EXTOp;
   logic [4:0]  ALUOp;
   logic [3:0]  NPCOp, LOADSel;
   logic [1:0]  GPRSel, WDSel;
   logic        illegal;
   logic [2:0]  state;
   logic [31:0] instret;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_instret;

   localparam int K_RALU = 0, K_IALU = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_J = 5, K_ILL = 6;
   localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4;

   typedef struct {
      logic [5:0] op, funct;
      int         cls;
      logic [4:0] alu;
      logic       srcb, ext;
      logic [1:0] gpr, wd;
      logic [3:0] lsel, npc;
      logic       link;
   } instr_t;

   instr_t itab[$];

   mc_ctrl dut (
      .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .IorD(IorD), .RegWrite(RegWrite), .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .ALUOp(ALUOp),
      .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel), .LOADSel(LOADSel), .illegal(illegal),
      .state(state), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic add_i(input logic [5:0] op, input logic [5:0] funct, input int cls,
                        input logic [4:0] alu, input logic srcb, input logic ext,
                        input logic [1:0] gpr, input logic [1:0] wd, input logic [3:0] lsel,
                        input logic [3:0] npc, input logic link);
      instr_t e;
      e.op = op; e.funct = funct; e.cls = cls; e.alu = alu; e.srcb = srcb; e.ext = ext;
      e.gpr = gpr; e.wd = wd; e.lsel = lsel; e.npc = npc; e.link = link;
      itab.push_back(e);
   endtask

   task automatic build_table();
      //     op     funct  class    alu srcb ext gpr wd lsel npc link
      add_i(6'h00, 6'h20, K_RALU,  1,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h21, K_RALU,  1,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h22, K_RALU,  2,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h23, K_RALU,  2,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h24, K_RALU,  3,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h25, K_RALU,  4,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h27, K_RALU,  8,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h26, K_RALU, 12,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h2A, K_RALU,  5,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h2B, K_RALU,  6,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h00, K_RALU,  7,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h02, K_RALU, 10,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h03, K_RALU, 13,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h04, K_RALU, 11,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h06, K_RALU, 15,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h07, K_RALU, 14,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h08, 6'h00, K_IALU,  1,  1,  1,  1,  0, 0,  0,  0);
      add_i(6'h0C, 6'h00, K_IALU,  3,  1,  0,  1,  0, 0,  0,  0);
      add_i(6'h0D, 6'h00, K_IALU,  4,  1,  0,  1,  0, 0,  0,  0);
      add_i(6'h0A, 6'h00, K_IALU,  5,  1,  1,  1,  0, 0,  0,  0);
      add_i(6'h0F, 6'h00, K_IALU,  9,  1,  0,  1,  0, 0,  0,  0);
      add_i(6'h23, 6'h00, K_LOAD,  1,  1,  1,  1,  1, 0,  0,  0);
      add_i(6'h20, 6'h00, K_LOAD,  1,  1,  1,  1,  1, 1,  0,  0);
      add_i(6'h24, 6'h00, K_LOAD,  1,  1,  1,  1,  1, 2,  0,  0);
      add_i(6'h21, 6'h00, K_LOAD,  1,  1,  1,  1,  1, 3,  0,  0);
      add_i(6'h25, 6'h00, K_LOAD,  1,  1,  1,  1,  1, 4,  0,  0);
      add_i(6'h2B, 6'h00, K_STORE, 1,  1,  1,  0,  0, 0,  0,  0);
      add_i(6'h28, 6'h00, K_STORE, 1,  1,  1,  0,  0, 5,  0,  0);
      add_i(6'h29, 6'h00, K_STORE, 1,  1,  1,  0,  0, 6,  0,  0);
      add_i(6'h04, 6'h00, K_BR,    2,  0,  1,  0,  0, 0,  0,  0);
      add_i(6'h05, 6'h00, K_BR,    2,  0,  1,  0,  0, 0,  0,  0);
      add_i(6'h02, 6'h00, K_J,     0,  0,  0,  0,  0, 0,  2,  0);
      add_i(6'h03, 6'h00, K_J,     0,  0,  0,  2,  2, 0,  2,  1);
      add_i(6'h00, 6'h08, K_J,     0,  0,  0,  0,  0, 0,  3,  0);
      add_i(6'h00, 6'h09, K_J,     0,  0,  0,  0,  2, 0,  4,  1);
      add_i(6'h3F, 6'h00, K_ILL,   0,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h3F, K_ILL,   0,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h00, 6'h01, K_ILL,   0,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h01, 6'h00, K_ILL,   0,  0,  0,  0,  0, 0,  0,  0);
      add_i(6'h2F, 6'h00, K_ILL,   0,  0,  0,  0,  0, 0,  0,  0);
   endtask

   function automatic int find_op(input logic [5:0] op, input logic [5:0] funct);
      for (int i = 0; i < itab.size(); i++)
         if (itab[i].op == op && (op != 6'h00 || itab[i].funct == funct)) return i;
      return 0;
   endfunction

   // Runs one instruction with fs FETCH stalls and ms MEM stalls; zmode 0/1 fixes Zero, 2 randomizes.
   task automatic run_instr(input int idx, input int fs, input int ms, input int zmode,
                            output int ncyc, output int nirw);
      instr_t in;
      int     ph[$];
      bit     rdy[$];
      logic [28:0] expv, obsv;
      logic   pcw, irw, mr, mw, iord, rw, ill, tk;
      logic [3:0] npc;
      in = itab[idx];
      for (int i = 0; i <= fs; i++) begin ph.push_back(P_F); rdy.push_back(i == fs); end
      ph.push_back(P_D); rdy.push_back(1'b0);
      if (in.cls != K_J && in.cls != K_ILL) begin ph.push_back(P_E); rdy.push_back(1'b0); end
      if (in.cls == K_LOAD || in.cls == K_STORE)
         for (int i = 0; i <= ms; i++) begin ph.push_back(P_M); rdy.push_back(i == ms); end
      if (in.cls == K_LOAD || in.cls == K_RALU || in.cls == K_IALU) begin
         ph.push_back(P_W); rdy.push_back(1'b0);
      end
      Op    = in.op;
      Funct = (in.op == 6'h00) ? in.funct : 6'($urandom);
      ncyc  = 0;
      nirw  = 0;
      for (int k = 0; k < ph.size(); k++) begin
         mem_ready = (ph[k] == P_F || ph[k] == P_M) ? rdy[k] : 1'($urandom);
         Zero      = (zmode == 2) ? 1'($urandom) : 1'(zmode);
         pcw = 0; irw = 0; mr = 0; mw = 0; iord = 0; rw = 0; ill = 0; npc = 4'd0;
         case (ph[k])
            P_F: begin mr = 1; irw = rdy[k]; end
            P_D: begin
               if (in.cls == K_J) begin pcw = 1; npc = in.npc; rw = in.link; end
               if (in.cls == K_ILL) begin pcw = 1; ill = 1; end
            end
            P_E: if (in.cls == K_BR) begin
               tk  = (in.op == 6'h05) ? !Zero : Zero;
               pcw = 1;
               npc = tk ? 4'd1 : 4'd0;
            end
            P_M: begin
               iord = 1;
               mr   = (in.cls == K_LOAD);
               mw   = (in.cls == K_STORE);
               pcw  = (in.cls == K_STORE) && rdy[k];
            end
            default: begin rw = 1; pcw = 1; end
         endcase
         if (ph[k] == P_F)
            expv = {pcw, irw, mr, mw, iord, rw, 1'b0, 1'b0, 5'd0, npc, 2'd0, 2'd0, 4'd0, ill, 3'(ph[k])};
         else
            expv = {pcw, irw, mr, mw, iord, rw, in.srcb, in.ext, in.alu, npc, in.gpr, in.wd,
                    in.lsel, ill, 3'(ph[k])};
         @(negedge clk);
         obsv = {PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, ALUSrcB, EXTOp, ALUOp,
                 NPCOp, GPRSel, WDSel, LOADSel, illegal, state};
         n_tests++;
         if (obsv !== expv) begin
            n_fail++;
            $display("FAIL outputs op=%h funct=%h phase=%0d: got %h expected %h",
                     Op, Funct, ph[k], obsv, expv);
         end
         n_tests++;
         if (instret !== exp_instret) begin
            n_fail++;
            $display("FAIL instret op=%h phase=%0d: got %0d expected %0d", Op, ph[k], instret, exp_instret);
         end
         if (pcw) exp_instret++;
         ncyc++;
         if (IRWrite === 1'b1) nirw++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1; mem_ready = 1; Zero = 0; Op = 6'h23; Funct = 6'h00;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_tests++;
         if ({PCWrite, IRWrite, MemRead, MemWrite, RegWrite, illegal, state, ALUOp} !== 14'd0
             || instret !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: strobes/state/alu=%h instret=%0d expected 0/0",
                     {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, illegal, state, ALUOp}, instret);
         end
         @(posedge clk); #1;
      end
      rst = 0; mem_ready = 0; exp_instret = 0;
      @(negedge clk);
      n_tests++;
      if (MemRead !== 1'b1 || state !== 3'd0 || IorD !== 1'b0 || IRWrite !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: MemRead=%b state=%0d IorD=%b IRWrite=%b expected 1/0/0/0",
                  MemRead, state, IorD, IRWrite);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      Op = 6'h28; Funct = 6'h00; Zero = 0;
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_tests++;
      if (MemWrite !== 1'b1 || state !== 3'd3) begin
         n_fail++;
         $display("FAIL sb_mem_stall: MemWrite=%b state=%0d expected 1/3", MemWrite, state);
      end
      @(posedge clk); #1;
      rst = 1; mem_ready = 0;
      @(negedge clk);
      n_tests++;
      if (MemWrite !== 1'b0 || PCWrite !== 1'b0 || RegWrite !== 1'b0 || state !== 3'd0) begin
         n_fail++;
         $display("FAIL sb_reset_cycle: MemWrite=%b PCWrite=%b RegWrite=%b state=%0d expected 0/0/0/0",
                  MemWrite, PCWrite, RegWrite, state);
      end
      @(posedge clk); #1;
      rst = 0; exp_instret = 0;
      @(negedge clk);
      n_tests++;
      if (state !== 3'd0 || MemRead !== 1'b1 || MemWrite !== 1'b0 || PCWrite !== 1'b0
          || instret !== 32'd0) begin
         n_fail++;
         $display("FAIL sb_refetch: state=%0d MemRead=%b MemWrite=%b PCWrite=%b instret=%0d expected 0/1/0/0/0",
                  state, MemRead, MemWrite, PCWrite, instret);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_addi();
      int nc, ni;
      run_instr(find_op(6'h08, 6'h05), 0, 0, 2, nc, ni);
      n_tests++;
      if (nc != 4 || instret !== 32'd1) begin
         n_fail++;
         $display("FAIL addi_cpi: cycles=%0d instret=%0d expected 4/1", nc, instret);
      end
   endtask

   task automatic test_lw_stall();
      int nc, ni;
      run_instr(find_op(6'h23, 6'h00), 2, 3, 2, nc, ni);
      n_tests++;
      if (nc != 10 || ni != 1) begin
         n_fail++;
         $display("FAIL lw_stall: cycles=%0d irwrite_pulses=%0d expected 10/1", nc, ni);
      end
   endtask

   task automatic test_branch();
      int nc, ni;
      run_instr(find_op(6'h04, 6'h00), 0, 0, 1, nc, ni);
      run_instr(find_op(6'h04, 6'h00), 0, 0, 0, nc, ni);
      run_instr(find_op(6'h05, 6'h00), 1, 0, 1, nc, ni);
      run_instr(find_op(6'h05, 6'h00), 0, 0, 0, nc, ni);
      n_tests++;
      if (nc != 3) begin
         n_fail++;
         $display("FAIL branch_cpi: cycles=%0d expected 3", nc);
      end
   endtask

   task automatic test_jump_link();
      int nc, ni;
      run_instr(find_op(6'h03, 6'h00), 0, 0, 2, nc, ni);
      n_tests++;
      if (nc != 2) begin n_fail++; $display("FAIL jal_cpi: cycles=%0d expected 2", nc); end
      run_instr(find_op(6'h00, 6'h09), 0, 0, 2, nc, ni);
      n_tests++;
      if (nc != 2) begin n_fail++; $display("FAIL jalr_cpi: cycles=%0d expected 2", nc); end
      run_instr(find_op(6'h02, 6'h00), 0, 0, 2, nc, ni);
      run_instr(find_op(6'h00, 6'h08), 0, 0, 2, nc, ni);
   endtask

   task automatic test_illegal();
      int nc, ni;
      run_instr(find_op(6'h3F, 6'h00), 0, 0, 2, nc, ni);
      n_tests++;
      if (nc != 2) begin n_fail++; $display("FAIL illegal_cpi: cycles=%0d expected 2", nc); end
      run_instr(find_op(6'h00, 6'h3F), 1, 0, 2, nc, ni);
   endtask

   task automatic test_random();
      int nc, ni;
      for (int i = 0; i < 200; i++)
         run_instr($urandom_range(itab.size() - 1), ($urandom % 2) ? $urandom_range(2) : 0,
                   ($urandom % 2) ? $urandom_range(3) : 0, 2, nc, ni);
   endtask

   initial begin
      rst = 1; Op = '0; Funct = '0; Zero = 0; mem_ready = 0; exp_instret = 0;
      build_table();
      @(posedge clk); #1;
      test_reset();
      test_reset_mid();
      test_addi();
      test_lw_stall();
      test_branch();
      test_jump_link();
      test_illegal();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
